wide_add_sequencer: RTL

- Multi-cycle wide add/subtract engine built around one shared 16-bit carry-lookahead adder instance.
- Processes a WORDS×16-bit operand pair one 16-bit slice per cycle, least-significant slice first, with a registered carry between slices.
- Used wherever operands wider than 16 bits must be added without replicating adder hardware.
- Valid/ready handshakes on input and output; one operation in flight at a time.

---
 rtl/wide_add_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide add/subtract engine: one shared 16-bit carry-lookahead
// adder walks the operands a 16-bit slice per cycle, LS slice first, with
// the inter-slice carry held in a register. Valid/ready on both sides,
// a single operation in flight.
module wide_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   op_a,
   input  logic [16*WORDS-1:0]   op_b,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   result,
   output logic                  cout,
   output logic                  ovf,
   output logic                  busy
);

   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                      state, state_nxt;
   logic [WORDS-1:0][15:0]      a_q;
   logic [WORDS-1:0][15:0]      b_q;      // already inverted for subtract
   logic [WORDS-1:0][15:0]      res_q;
   logic                        carry_q;
   logic [IW-1:0]               idx_q;
   logic                        cout_q;
   logic                        ovf_q;

   logic [15:0]                 a_sl, b_sl, sum_sl;
   logic                        cla_co;

   // Two-level carry lookahead: 4-bit groups with group generate/propagate,
   // group carries resolved across the four groups.
   function automatic logic [16:0] cla16(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic        cin);
      logic [15:0] g, p;
      logic [16:0] c;
      logic [3:0]  gg, gp;
      logic [4:0]  gc;
      g = a & b;
      p = a ^ b;
      for (int k = 0; k < 4; k++) begin
         gp[k] = &p[4*k +: 4];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
      gc[0] = cin;
      for (int k = 0; k < 4; k++)
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      c = '0;
      for (int i = 0; i < 16; i++) begin
         if (i % 4 == 0)
            c[i] = gc[i/4];
         else
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
      c[16] = gc[4];
      return {c[16], p ^ c[15:0]};
   endfunction

   // Shared adder on the currently selected slice.
   always_comb begin
      a_sl = a_q[idx_q];
      b_sl = b_q[idx_q];
      {cla_co, sum_sl} = cla16(a_sl, b_sl, carry_q);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: accept in IDLE, step slices in RUN, hand off in DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)       state_nxt = RUN;
         RUN:     if (idx_q == LAST)  state_nxt = DONE;
         DONE:    if (out_ready)      state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Operand capture, per-slice result write-back and final flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= op_a;
                  b_q     <= sub ? ~op_b : op_b;
                  carry_q <= sub;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               res_q[idx_q] <= sum_sl;
               carry_q      <= cla_co;
               idx_q        <= idx_q + 1'b1;
               if (idx_q == LAST) begin
                  cout_q <= cla_co;
                  ovf_q  <= (a_sl[15] == b_sl[15]) && (sum_sl[15] != a_sl[15]);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign result    = res_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule
